// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with one shared period counter and per-channel duty.
// Period, duty and alignment mode are double-buffered and switch only at a period boundary.
module pwm_multi_gen #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic                          align_center_i,
    input  logic [CNT_WIDTH-1:0]          period_i,
    input  logic [CHANNELS*CNT_WIDTH-1:0] duty_i,
    input  logic                          load_i,
    output logic [CHANNELS-1:0]           pwm_out_o,
    output logic                          period_start_o,
    output logic                          load_ack_o
);

    localparam int DW = CHANNELS * CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 act_align_q, act_align_d;
    logic [CNT_WIDTH-1:0] act_period_q, act_period_d;
    logic [DW-1:0]        act_duty_q, act_duty_d;
    logic                 pend_align_q, pend_align_d;
    logic [CNT_WIDTH-1:0] pend_period_q, pend_period_d;
    logic [DW-1:0]        pend_duty_q, pend_duty_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [CHANNELS-1:0]  pwm_q, pwm_d;
    logic                 ps_q, ps_d;
    logic                 ack_q, ack_d;

    logic                 boundary_s;
    logic                 eff_align_s;
    logic [CNT_WIDTH-1:0] eff_period_s;
    logic [DW-1:0]        eff_duty_s;

    // Settings in force this cycle: a boundary promotes a same-cycle load first, else pending.
    always_comb begin
        boundary_s   = enable_i && (state_q == UP) && (cnt_q == CNT_ZERO);
        eff_align_s  = act_align_q;
        eff_period_s = act_period_q;
        eff_duty_s   = act_duty_q;
        if (boundary_s && load_i) begin
            eff_align_s  = align_center_i;
            eff_period_s = period_i;
            eff_duty_s   = duty_i;
        end else if (boundary_s && pend_valid_q) begin
            eff_align_s  = pend_align_q;
            eff_period_s = pend_period_q;
            eff_duty_s   = pend_duty_q;
        end else begin
            eff_align_s  = act_align_q;
            eff_period_s = act_period_q;
            eff_duty_s   = act_duty_q;
        end
    end

    // Next-state logic: counter sequencing, buffer promotion and registered outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        act_align_d   = eff_align_s;
        act_period_d  = eff_period_s;
        act_duty_d    = eff_duty_s;
        pend_align_d  = pend_align_q;
        pend_period_d = pend_period_q;
        pend_duty_d   = pend_duty_q;
        pend_valid_d  = pend_valid_q;
        pwm_d         = {CHANNELS{1'b0}};
        ps_d          = 1'b0;
        ack_d         = 1'b0;

        if (boundary_s) begin
            pend_valid_d = 1'b0;
            ack_d        = load_i || pend_valid_q;
            ps_d         = 1'b1;
        end else if (load_i) begin
            pend_align_d  = align_center_i;
            pend_period_d = period_i;
            pend_duty_d   = duty_i;
            pend_valid_d  = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end

        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = UP;
                    cnt_d   = CNT_ZERO;
                end
                UP: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        pwm_d[i] = (cnt_q < eff_duty_s[i*CNT_WIDTH +: CNT_WIDTH]);
                    end
                    // Terminal count: edge mode wraps; center mode turns unless P<=1.
                    if (cnt_q >= eff_period_s) begin
                        if (eff_align_s && (eff_period_s > CNT_ONE)) begin
                            state_d = DOWN;
                            cnt_d   = eff_period_s - CNT_ONE;
                        end else begin
                            state_d = UP;
                            cnt_d   = CNT_ZERO;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                DOWN: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        pwm_d[i] = (cnt_q < eff_duty_s[i*CNT_WIDTH +: CNT_WIDTH]);
                    end
                    if (cnt_q <= CNT_ONE) begin
                        state_d = UP;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, buffer and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ZERO;
            act_align_q   <= 1'b0;
            act_period_q  <= CNT_ZERO;
            act_duty_q    <= {DW{1'b0}};
            pend_align_q  <= 1'b0;
            pend_period_q <= CNT_ZERO;
            pend_duty_q   <= {DW{1'b0}};
            pend_valid_q  <= 1'b0;
            pwm_q         <= {CHANNELS{1'b0}};
            ps_q          <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            act_align_q   <= act_align_d;
            act_period_q  <= act_period_d;
            act_duty_q    <= act_duty_d;
            pend_align_q  <= pend_align_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            pend_valid_q  <= pend_valid_d;
            pwm_q         <= pwm_d;
            ps_q          <= ps_d;
            ack_q         <= ack_d;
        end
    end

    assign pwm_out_o      = pwm_q;
    assign period_start_o = ps_q;
    assign load_ack_o     = ack_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: table of whole-period patterns, directed
// buffering/enable/reset sequences, and a random run against a phase-index reference model.
module tb_pwm_multi_gen;

    localparam int CH = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable_in = 1'b0;
    logic             align_in = 1'b0;
    logic             load_in = 1'b0;
    logic [CW-1:0]    period_in = '0;
    logic [CH*CW-1:0] duty_in = '0;
    logic [CH-1:0]    pwm_out;
    logic             period_start;
    logic             load_ack;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: position k inside the period, active and pending settings
    bit          m_run;
    int          m_k;
    bit          m_amode, m_pmode, m_pv;
    int          m_ap, m_pp;
    int          m_ad[CH];
    int          m_pd[CH];
    logic [CH-1:0] exp_pwm;
    logic        exp_ps, exp_ack;

    // whole-period measurement results
    int r_len, r_ack_first, r_acks;
    int r_hi[CH];

    typedef struct {
        bit                    align;
        int                    p;
        logic [CH-1:0][CW-1:0] d;
        int                    len;
        logic [CH-1:0][CW-1:0] h;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    pwm_multi_gen #(.CHANNELS(CH), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_i       (enable_in),
        .align_center_i (align_in),
        .period_i       (period_in),
        .duty_i         (duty_in),
        .load_i         (load_in),
        .pwm_out_o      (pwm_out),
        .period_start_o (period_start),
        .load_ack_o     (load_ack)
    );

    function automatic int m_len(bit mode, int p);
        if (p == 0) return 1;
        return mode ? 2 * p : p + 1;
    endfunction

    function automatic int m_cnt(bit mode, int p, int k);
        return (mode && k > p) ? 2 * p - k : k;
    endfunction

    task automatic model_reset();
        m_run = 0; m_k = 0; m_amode = 0; m_pmode = 0; m_pv = 0; m_ap = 0; m_pp = 0;
        for (int i = 0; i < CH; i++) begin m_ad[i] = 0; m_pd[i] = 0; end
        exp_pwm = '0; exp_ps = 0; exp_ack = 0;
    endtask

    task automatic capture_pending();
        m_pmode = align_in; m_pp = int'(period_in); m_pv = 1;
        for (int i = 0; i < CH; i++) m_pd[i] = int'(duty_in[i*CW +: CW]);
    endtask

    // Predict the outputs that appear after the coming clock edge.
    task automatic model_update();
        int c;
        exp_pwm = '0; exp_ps = 0; exp_ack = 0;
        if (!enable_in) begin
            m_run = 0;
            if (load_in) capture_pending();
        end else if (!m_run) begin
            m_run = 1; m_k = 0;
            if (load_in) capture_pending();
        end else begin
            if (m_k == 0) begin
                if (load_in) begin
                    m_amode = align_in; m_ap = int'(period_in); exp_ack = 1;
                    for (int i = 0; i < CH; i++) m_ad[i] = int'(duty_in[i*CW +: CW]);
                end else if (m_pv) begin
                    m_amode = m_pmode; m_ap = m_pp; exp_ack = 1;
                    for (int i = 0; i < CH; i++) m_ad[i] = m_pd[i];
                end
                m_pv = 0;
                exp_ps = 1;
            end else if (load_in) begin
                capture_pending();
            end
            c = m_cnt(m_amode, m_ap, m_k);
            for (int i = 0; i < CH; i++) exp_pwm[i] = (c < m_ad[i]);
            m_k = (m_k + 1) % m_len(m_amode, m_ap);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        vectors++;
        if ({pwm_out, period_start, load_ack} !== {exp_pwm, exp_ps, exp_ack}) begin
            miscompares++;
            $display("FAIL model t=%0t: got pwm=%b ps=%b ack=%b, expected pwm=%b ps=%b ack=%b",
                     $time, pwm_out, period_start, load_ack, exp_pwm, exp_ps, exp_ack);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_duty(input int ch, input int v);
        duty_in[ch*CW +: CW] = CW'(v);
    endtask

    task automatic wait_ps();
        bit found;
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            step();
            if (period_start) found = 1;
        end
        if (!found) check("wait_ps timeout", 0, 1);
    endtask

    // Starting on a period_start sample, measure one period; optional D0 loads at sample la/lb.
    task automatic run_period(input int la, input int da, input int lb, input int db);
        bit done;
        r_len = 1; r_ack_first = int'(load_ack); r_acks = int'(load_ack);
        for (int i = 0; i < CH; i++) r_hi[i] = int'(pwm_out[i]);
        done = 0;
        for (int n = 0; n < 600 && !done; n++) begin
            if (n == la) begin load_in = 1; set_duty(0, da); end
            if (n == lb) begin load_in = 1; set_duty(0, db); end
            step();
            load_in = 0;
            if (period_start) begin
                done = 1;
            end else begin
                r_len++;
                r_acks += int'(load_ack);
                for (int i = 0; i < CH; i++) r_hi[i] += int'(pwm_out[i]);
            end
        end
        if (!done) check("period timeout", 0, 1);
    endtask

    task automatic configure(input bit a, input int p, input int d0, input int d1,
                             input int d2, input int d3);
        enable_in = 0;
        step();
        align_in = a; period_in = CW'(p);
        set_duty(0, d0); set_duty(1, d1); set_duty(2, d2); set_duty(3, d3);
        load_in = 1;
        step();
        load_in = 0;
        enable_in = 1;
        wait_ps();
    endtask

    task automatic add(input int idx, input bit a, input int p, input int d0, input int d1,
                       input int d2, input int d3, input int len, input int h0, input int h1,
                       input int h2, input int h3);
        tbl[idx].align = a; tbl[idx].p = p; tbl[idx].len = len;
        tbl[idx].d[0] = CW'(d0); tbl[idx].d[1] = CW'(d1);
        tbl[idx].d[2] = CW'(d2); tbl[idx].d[3] = CW'(d3);
        tbl[idx].h[0] = CW'(h0); tbl[idx].h[1] = CW'(h1);
        tbl[idx].h[2] = CW'(h2); tbl[idx].h[3] = CW'(h3);
    endtask

    initial begin
        bit en_r;
        model_reset();
        add(0, 1'b0, 9, 3, 0, 10, 9,       10, 3, 0, 10, 9);
        add(1, 1'b1, 4, 2, 0, 5, 4,        8,  3, 0, 8, 7);
        add(2, 1'b0, 0, 0, 1, 5, 0,        1,  0, 1, 1, 0);
        add(3, 1'b1, 1, 1, 2, 0, 1,        2,  1, 2, 0, 1);
        add(4, 1'b0, 5, 0, 65535, 5, 1,    6,  0, 6, 5, 1);
        add(5, 1'b1, 3, 3, 1, 2, 4,        6,  5, 1, 3, 6);

        #1;
        check("reset pwm", int'(pwm_out), 0);
        check("reset ps", int'(period_start), 0);
        check("reset ack", int'(load_ack), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1;

        // whole-period patterns
        for (int t = 0; t < 6; t++) begin
            configure(tbl[t].align, tbl[t].p, int'(tbl[t].d[0]), int'(tbl[t].d[1]),
                      int'(tbl[t].d[2]), int'(tbl[t].d[3]));
            run_period(-1, 0, -1, 0);
            check($sformatf("tbl%0d ack", t), r_ack_first, 1);
            check($sformatf("tbl%0d len", t), r_len, tbl[t].len);
            for (int i = 0; i < CH; i++)
                check($sformatf("tbl%0d hi ch%0d", t, i), r_hi[i], int'(tbl[t].h[i]));
            run_period(-1, 0, -1, 0);
            check($sformatf("tbl%0d len2", t), r_len, tbl[t].len);
            check($sformatf("tbl%0d acks2", t), r_acks, 0);
        end

        // mid-period load waits for the next boundary
        configure(1'b0, 9, 3, 0, 10, 9);
        run_period(3, 6, -1, 0);
        check("midload old hi", r_hi[0], 3);
        check("midload acks", r_acks, 1);
        run_period(-1, 0, -1, 0);
        check("midload new ack", r_ack_first, 1);
        check("midload new hi", r_hi[0], 6);
        check("midload single ack", r_acks, 1);

        // two loads in one period: last wins, one ack
        run_period(2, 5, 5, 7);
        check("twoload old hi", r_hi[0], 6);
        check("twoload no ack", r_acks, 0);
        run_period(-1, 0, -1, 0);
        check("twoload hi", r_hi[0], 7);
        check("twoload one ack", r_acks, 1);

        // load on the boundary cycle itself
        run_period(9, 2, -1, 0);
        check("bndload old hi", r_hi[0], 7);
        check("bndload no ack", r_acks, 0);
        run_period(-1, 0, -1, 0);
        check("bndload ack", r_ack_first, 1);
        check("bndload hi", r_hi[0], 2);

        // disable mid-period, load while idle, re-enable
        step(); step(); step();
        enable_in = 0;
        step();
        check("disable pwm", int'(pwm_out), 0);
        check("disable ps", int'(period_start), 0);
        set_duty(0, 4); load_in = 1;
        step();
        load_in = 0; enable_in = 1;
        wait_ps();
        check("reenable ack", int'(load_ack), 1);
        run_period(-1, 0, -1, 0);
        check("reenable hi", r_hi[0], 4);
        check("reenable len", r_len, 10);

        // async reset mid-period with a pending load
        step(); step(); step();
        set_duty(0, 5); load_in = 1;
        step();
        load_in = 0;
        step();
        #2;
        reset = 0;
        #1;
        check("async rst pwm", int'(pwm_out), 0);
        check("async rst ps", int'(period_start), 0);
        check("async rst ack", int'(load_ack), 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1;
        enable_in = 1;
        wait_ps();
        check("post rst ack", int'(load_ack), 0);
        run_period(-1, 0, -1, 0);
        check("post rst len", r_len, 1);
        check("post rst hi ch0", r_hi[0], 0);
        check("post rst hi ch2", r_hi[2], 0);

        // randomized run against the model
        en_r = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) en_r = ~en_r;
            enable_in = en_r;
            load_in   = ($urandom_range(0, 7) == 0);
            align_in  = $urandom_range(0, 1) != 0;
            period_in = CW'($urandom_range(0, 12));
            for (int i = 0; i < CH; i++) set_duty(i, int'($urandom_range(0, 14)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
